pipeline_hazard_ctrl: RTL

//  Central sequencer for the 5-stage vector pipeline (F/D/E/M/W, 48-bit lanes, 16 regs). Drives stall/flush
//  and enables of all pipeline registers, incl. EX/MEM and MEM/WB. Resolves load-use hazards, E-stage

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipeline_hazard_ctrl_fwd_select.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: sequencer states and
// operand-forwarding select encodings.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        MEM_WAIT,
        FLUSH
    } ctrl_state_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    // Wide enough for the largest legal wait-state timeout (255).
    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Forwarding compare for one E-stage source operand: the newest in-flight
// writer (M before W) wins; register 0 is an ordinary register.
module fwd_select
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 4
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] wa3_m,
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] wa3_w,
    input  logic              reg_write_w,
    output fwd_sel_t          sel
);

    always_comb begin
        sel = FWD_RF;
        if (reg_write_m && (wa3_m == src)) begin
            sel = FWD_M;
        end else if (reg_write_w && (wa3_w == src)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/enable sequencer for the 5-stage pipeline: branch flush,
// data-memory wait states with timeout, load-use stalls and E-stage forwarding.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW      = 4,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned PERF_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ra1_d,
    input  logic [REG_AW-1:0] ra2_d,
    input  logic [REG_AW-1:0] ra1_e,
    input  logic [REG_AW-1:0] ra2_e,
    input  logic [REG_AW-1:0] wa3_e,
    input  logic              reg_write_e,
    input  logic              mem_to_reg_e,
    input  logic [REG_AW-1:0] wa3_m,
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] wa3_w,
    input  logic              reg_write_w,
    input  logic              mem_access_m,
    input  logic              mem_ready,
    input  logic              pcsrc_w,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              en_m,
    output logic              en_w,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              mem_req,
    output logic              mem_err,
    output logic [PERF_W-1:0] stall_cycles
);

    ctrl_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

    fwd_sel_t fwd_a_sel, fwd_b_sel;
    logic     load_use;
    logic     timeout;

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .src         (ra1_e),
        .wa3_m       (wa3_m),
        .reg_write_m (reg_write_m),
        .wa3_w       (wa3_w),
        .reg_write_w (reg_write_w),
        .sel         (fwd_a_sel)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .src         (ra2_e),
        .wa3_m       (wa3_m),
        .reg_write_m (reg_write_m),
        .wa3_w       (wa3_w),
        .reg_write_w (reg_write_w),
        .sel         (fwd_b_sel)
    );

    assign load_use = mem_to_reg_e && reg_write_e && ((wa3_e == ra1_d) || (wa3_e == ra2_d));
    assign timeout  = (cnt_q == CNT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= INIT;
            cnt_q          <= '0;
            mem_err_q      <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mem_err_q      <= mem_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_err_d = mem_err_q;
        case (state_q)
            INIT: state_d = RUN;
            RUN: begin
                if (pcsrc_w) begin
                    state_d = FLUSH;
                end else if (mem_access_m && !mem_ready) begin
                    state_d = MEM_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                // A retiring branch makes the waiting access wrong-path; drop it without flagging an error.
                if (pcsrc_w) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else if (mem_ready) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (timeout) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    mem_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FLUSH:   state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        en_m    = 1'b1;
        en_w    = 1'b1;
        mem_req = 1'b0;
        if (rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (pcsrc_w) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                        flush_m = 1'b1;
                    end else if (mem_access_m && !mem_ready) begin
                        mem_req = 1'b1;
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        en_m    = 1'b0;
                    end else if (mem_access_m) begin
                        mem_req = 1'b1;
                    end else if (load_use) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (pcsrc_w) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                        flush_m = 1'b1;
                    end else begin
                        mem_req = 1'b1;
                        if (!mem_ready) begin
                            stall_f = 1'b1;
                            stall_d = 1'b1;
                            // On timeout the stuck M op is replaced by a bubble instead of held.
                            if (timeout) begin
                                flush_m = 1'b1;
                            end else begin
                                en_m = 1'b0;
                            end
                        end
                    end
                end
                FLUSH: begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end
                default: begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                    flush_m = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_f && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
    end

    assign fwd_a_e      = (rst || state_q == INIT) ? FWD_RF : fwd_a_sel;
    assign fwd_b_e      = (rst || state_q == INIT) ? FWD_RF : fwd_b_sel;
    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_cycles_q;

endmodule
